// File: rtl/clk_div_pkg.sv
`default_nettype none
// =============================================================================
// Module      : clk_div_pkg
// Description : Shared types and config legalisation for the clk_div_multi
//               divider slice.
// Revision    : 1.0 - initial release
// =============================================================================
package clk_div_pkg;

    localparam int C_DIV_W = 20;

    typedef logic [C_DIV_W-1:0] div_t;

    typedef struct packed {
        div_t div;
        div_t high;
    } div_cfg_t;

    // A period shorter than two cycles cannot hold both a tick and a level
    // change, so it is stretched to two; high time is kept as written.
    function automatic div_cfg_t legalise(input div_cfg_t cfg);
        div_cfg_t res;
        res = cfg;
        if (cfg.div < div_t'(2)) begin
            res.div = div_t'(2);
        end
        return res;
    endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// =============================================================================
// Module      : clk_div_chan
// Description : One divider channel: period counter, active/pending config
//               and registered clock-level and tick outputs.
// Revision    : 1.0 - initial release
// =============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter div_t DEFAULT_DIV  = div_t'(100000),
    parameter div_t DEFAULT_HIGH = div_t'(50000)
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     en_i,
    input  logic     sync_i,
    input  logic     cfg_we_i,
    input  div_cfg_t cfg_i,
    output logic     cfg_pend_o,
    output logic     clk_o,
    output logic     tick_o
);

    localparam div_cfg_t C_RESET_CFG = legalise('{div: DEFAULT_DIV, high: DEFAULT_HIGH});

    div_t     r_cnt;
    div_cfg_t r_act;
    div_cfg_t r_pend;
    logic     r_pend_vld;
    logic     r_run;
    logic     r_clk;
    logic     r_tick;

    logic     w_wrap;
    logic     w_restart;
    logic     w_apply;
    div_t     w_cnt_d;
    div_cfg_t w_act_d;

    // r_run lags en_i so the first enabled cycle restarts the period at zero.
    always_comb begin
        w_wrap    = r_run && (r_cnt == (r_act.div - 1'b1));
        w_restart = sync_i || w_wrap || !r_run;
        w_apply   = w_restart || !en_i;
        w_cnt_d   = r_cnt + 1'b1;
        if (!en_i || w_restart) begin
            w_cnt_d = '0;
        end
        w_act_d = r_act;
        if (w_apply && r_pend_vld) begin
            w_act_d = legalise(r_pend);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_act      <= C_RESET_CFG;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_run      <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_run <= en_i;
            r_cnt <= w_cnt_d;
            r_act <= w_act_d;
            // A write landing on a boundary stays pending for the next one.
            if (cfg_we_i) begin
                r_pend     <= cfg_i;
                r_pend_vld <= 1'b1;
            end else if (w_apply) begin
                r_pend_vld <= 1'b0;
            end
            r_tick <= en_i && (w_cnt_d == '0);
            r_clk  <= en_i && (w_cnt_d < w_act_d.high);
        end
    end

    assign cfg_pend_o = r_pend_vld;
    assign clk_o      = r_clk;
    assign tick_o     = r_tick;

endmodule : clk_div_chan
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// =============================================================================
// Module      : clk_div_multi
// Description : Multi-channel programmable clock divider / tick generator.
//               DIV_W must equal clk_div_pkg::C_DIV_W.
// Revision    : 1.0 - initial release
// =============================================================================
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int               NUM_CH       = 4,
    parameter int               DIV_W        = C_DIV_W,
    parameter logic [DIV_W-1:0] DEFAULT_DIV  = DIV_W'(100000),
    parameter logic [DIV_W-1:0] DEFAULT_HIGH = DIV_W'(50000)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_CH-1:0]           en_i,
    input  logic                        sync_i,
    input  logic                        cfg_we_i,
    input  logic [$clog2(NUM_CH):0]     cfg_ch_i,
    input  logic [DIV_W-1:0]            cfg_div_i,
    input  logic [DIV_W-1:0]            cfg_high_i,
    output logic [NUM_CH-1:0]           cfg_pend_o,
    output logic [NUM_CH-1:0]           clk_o,
    output logic [NUM_CH-1:0]           tick_o
);

    localparam int CH_W = $clog2(NUM_CH) + 1;

    div_cfg_t w_cfg;

    assign w_cfg.div  = div_t'(cfg_div_i);
    assign w_cfg.high = div_t'(cfg_high_i);

    // Indices at or above NUM_CH match no channel, so such writes are dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_we;

        assign w_we = cfg_we_i && (cfg_ch_i == CH_W'(g));

        clk_div_chan #(
            .DEFAULT_DIV  (div_t'(DEFAULT_DIV)),
            .DEFAULT_HIGH (div_t'(DEFAULT_HIGH))
        ) u_chan (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .en_i       (en_i[g]),
            .sync_i     (sync_i),
            .cfg_we_i   (w_we),
            .cfg_i      (w_cfg),
            .cfg_pend_o (cfg_pend_o[g]),
            .clk_o      (clk_o[g]),
            .tick_o     (tick_o[g])
        );
    end

endmodule : clk_div_multi
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// =============================================================================
// Module      : tb_clk_div_multi
// Description : Directed self-checking bench for clk_div_multi (defaults
//               scaled to 1000/500 to keep periods short).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_clk_div_multi;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 20;

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_high;
    logic [NUM_CH-1:0] cfg_pend;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_multi #(
        .NUM_CH       (NUM_CH),
        .DIV_W        (DIV_W),
        .DEFAULT_DIV  (20'd1000),
        .DEFAULT_HIGH (20'd500)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .sync_i     (sync),
        .cfg_we_i   (cfg_we),
        .cfg_ch_i   (cfg_ch),
        .cfg_div_i  (cfg_div),
        .cfg_high_i (cfg_high),
        .cfg_pend_o (cfg_pend),
        .clk_o      (clk_out),
        .tick_o     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int dv, input int hi);
        cfg_we   = 1'b1;
        cfg_ch   = 3'(ch);
        cfg_div  = 20'(dv);
        cfg_high = 20'(hi);
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic do_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    task automatic wait_tick(input int ch, input int lim, output int n);
        n = 0;
        while (!tick[ch] && n < lim) begin
            step();
            n++;
        end
    endtask

    // Entered on a tick cycle; returns cycles to the next tick and high cycles.
    task automatic measure(input int ch, input int lim, output int n, output int hi);
        n  = 0;
        hi = 0;
        do begin
            if (clk_out[ch]) hi++;
            n++;
            step();
        end while (!tick[ch] && n < lim);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int hi;
        logic [3:0] exp_tick;

        rst_n = 1'b0; en = 4'hF; sync = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;

        // Reset state and default configuration
        repeat (3) step();
        check("rst_clk", clk_out, 4'h0);
        check("rst_tick", tick, 4'h0);
        check("rst_pend", cfg_pend, 4'h0);
        rst_n = 1'b1;
        wait_tick(0, 10, n);
        check("first_tick_lat", n, 1);
        check("first_tick_all", tick, 4'hF);
        check("first_clk_all", clk_out, 4'hF);
        measure(0, 1100, n, hi);
        check("def_period", n, 1000);
        check("def_high", hi, 500);

        // Mid-period write held pending until wrap
        repeat (10) step();
        cfg_write(1, 10, 3);
        check("pend_set", cfg_pend, 4'b0010);
        wait_tick(1, 1100, n);
        check("pend_wait", n, 989);
        check("pend_clr", cfg_pend, 4'b0000);
        measure(1, 20, n, hi);
        check("ch1_period", n, 10);
        check("ch1_high", hi, 3);
        measure(1, 20, n, hi);
        check("ch1_period2", n, 10);
        check("ch1_high2", hi, 3);

        // Legalisation
        cfg_write(2, 1, 5);
        do_sync();
        check("sync_tick_all", tick, 4'hF);
        measure(2, 20, n, hi);
        check("leg_div_period", n, 2);
        check("leg_div_high", hi, 2);
        cfg_write(2, 4, 0);
        do_sync();
        measure(2, 20, n, hi);
        check("zero_high_period", n, 4);
        check("zero_high_high", hi, 0);

        // Phase alignment with sync
        cfg_write(0, 5, 2);
        cfg_write(2, 7, 3);
        do_sync();
        check("sync_apply_tick", tick, 4'hF);
        repeat (13) step();
        do_sync();
        for (int i = 0; i <= 20; i++) begin
            exp_tick = {(i % 1000) == 0, (i % 7) == 0, (i % 10) == 0, (i % 5) == 0};
            check($sformatf("sync_tick_i%0d", i), tick, exp_tick);
            step();
        end

        // Write on the exact wrap cycle of ch1 (cycle 29 after sync, cnt=9)
        repeat (8) step();
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 20'd6; cfg_high = 20'd1;
        step();
        cfg_we = 1'b0;
        check("wrapw_tick", tick[1], 1'b1);
        check("wrapw_pend", cfg_pend, 4'b0010);
        measure(1, 20, n, hi);
        check("wrapw_old_period", n, 10);
        check("wrapw_old_high", hi, 3);
        check("wrapw_pend_clr", cfg_pend, 4'b0000);
        measure(1, 20, n, hi);
        check("wrapw_new_period", n, 6);
        check("wrapw_new_high", hi, 1);

        // Out-of-range channel index is ignored
        cfg_write(4, 3, 1);
        check("badch_pend", cfg_pend, 4'b0000);
        wait_tick(1, 20, n);
        measure(1, 20, n, hi);
        check("badch_ch1_period", n, 6);
        wait_tick(0, 20, n);
        measure(0, 20, n, hi);
        check("badch_ch0_period", n, 5);
        check("badch_ch0_high", hi, 2);

        // Enable drop during high phase, re-enable after 3 cycles
        wait_tick(3, 1100, n);
        repeat (10) step();
        check("en_pre_high", clk_out[3], 1'b1);
        en = 4'b0111;
        step();
        check("en_off_clk", clk_out[3], 1'b0);
        check("en_off_tick", tick[3], 1'b0);
        step();
        step();
        check("en_off_clk3", clk_out[3], 1'b0);
        en = 4'hF;
        step();
        check("en_on_tick", tick[3], 1'b1);
        check("en_on_clk", clk_out[3], 1'b1);
        measure(3, 1100, n, hi);
        check("en_on_period", n, 1000);
        check("en_on_high", hi, 500);

        // Asynchronous reset mid-period
        cfg_write(0, 9, 4);
        check("arst_pre_pend", cfg_pend, 4'b0001);
        check("arst_pre_clk3", clk_out[3], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_clk", clk_out, 4'h0);
        check("arst_tick", tick, 4'h0);
        check("arst_pend", cfg_pend, 4'h0);
        step();
        rst_n = 1'b1;
        wait_tick(0, 10, n);
        check("arst_restart_lat", n, 1);
        measure(0, 1100, n, hi);
        check("arst_def_period", n, 1000);
        check("arst_def_high", hi, 500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_clk_div_multi
`default_nettype wire
